axil_reg_bridge: RTL and testbench

AXI4-Lite slave-to-simple-register-bus bridge. It sits directly upstream of the timer peripheral's register port: it converts CPU-side AXI4-Lite transactions into single-cycle wen/ren strobes and returns wready/rvalid completions as B/R responses. Write and read channels run independently, with one outstanding transaction per channel. Accesses outside the decode window are rejected locally with DECERR.

---
 rtl/axil_pkg.sv | 26 ++
 rtl/axil_reg_chan.sv | 102 ++++++++++
 rtl/axil_reg_bridge.sv | 146 ++++++++++++++
 tb/tb_axil_reg_bridge.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite to register-bus bridge.
package axil_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Generic channel FSM encoding; the write/read views below share it
    typedef enum logic [1:0] {ChIdle, ChReq, ChWait, ChResp} chan_state_e;

    typedef enum logic [1:0] {WIdle, WReq, WWait, WResp} w_state_e;

    typedef enum logic [1:0] {RIdle, RReq, RWait, RResp} r_state_e;

    function automatic logic addr_in_window(input logic [31:0] addr, input logic [31:0] base,
                                            input int unsigned win_bits);
        return (addr >> win_bits) == (base >> win_bits);
    endfunction

    function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                                input int unsigned win_bits);
        return addr & ((32'd1 << win_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/axil_reg_chan.sv
// Generic request/wait/response channel FSM, used once for writes and once for reads.
// With AXIL_BRIDGE_TIMEOUT_EN defined, WAIT gives up after TIMEOUT_CYC cycles (SLVERR).
module axil_reg_chan
    import axil_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       in_win,
    input  logic       done,
    input  logic       resp_ready,
    output logic       req,
    output logic       resp_valid,
    output logic [1:0] resp,
    output logic [1:0] state
);

    chan_state_e state_q, state_d;
    logic [1:0]  resp_q, resp_d;
    logic        timeout;

`ifdef AXIL_BRIDGE_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CntW-1:0] cnt_q;

    // Count cycles spent in WAIT; anywhere else (including REQ) it sits at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (state_q == ChWait) begin
            cnt_q <= cnt_q + CntW'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout = (state_q == ChWait) && (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // State and response-code registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ChIdle;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
        end
    end

    // Next state; completion wins over a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        req     = 1'b0;
        unique case (state_q)
            ChIdle: begin
                if (start) begin
                    if (in_win) begin
                        state_d = ChReq;
                    end else begin
                        state_d = ChResp;
                        resp_d  = RESP_DECERR;
                    end
                end
            end
            ChReq: begin
                req = 1'b1;
                if (done) begin
                    state_d = ChResp;
                    resp_d  = RESP_OKAY;
                end else begin
                    state_d = ChWait;
                end
            end
            ChWait: begin
                if (done) begin
                    state_d = ChResp;
                    resp_d  = RESP_OKAY;
                end else if (timeout) begin
                    state_d = ChResp;
                    resp_d  = RESP_SLVERR;
                end
            end
            ChResp: begin
                if (resp_ready) begin
                    state_d = ChIdle;
                end
            end
            default: state_d = ChIdle;
        endcase
    end

    assign resp_valid = (state_q == ChResp);
    assign resp       = resp_q;
    assign state      = state_q;

endmodule

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave to single-cycle register-bus bridge, one outstanding access per channel.
// Optional build macro: AXIL_BRIDGE_TIMEOUT_EN (WAIT-state completion timeout).
module axil_reg_bridge
    import axil_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int unsigned WIN_BITS    = 12,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        wen,
    output logic [3:0]  wstrb,
    input  logic        wready,
    output logic [31:0] raddr,
    output logic        ren,
    input  logic [31:0] rdata,
    input  logic        rvalid
);

    logic        aw_held_q, w_held_q, ar_held_q;
    logic [31:0] awaddr_q, wdata_q, araddr_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  w_chan_state, r_chan_state;
    w_state_e    w_state;
    r_state_e    r_state;
    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic        w_start, r_start, r_capture;

    assign w_state = w_state_e'(w_chan_state);
    assign r_state = r_state_e'(r_chan_state);

    // Each address/data slot accepts one beat and refuses more until its response is taken
    assign aw_hs = s_awvalid & ~aw_held_q;
    assign w_hs  = s_wvalid & ~w_held_q;
    assign ar_hs = s_arvalid & ~ar_held_q;
    assign b_hs  = s_bvalid & s_bready;
    assign r_hs  = s_rvalid & s_rready;

    assign w_start   = aw_held_q & w_held_q & (w_state == WIdle);
    assign r_start   = ar_held_q & (r_state == RIdle);
    assign r_capture = rvalid & ((r_state == RReq) | (r_state == RWait));

    // Hold AW/W/AR beats until the matching B/R handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            ar_held_q <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= s_awaddr;
            end else if (b_hs) begin
                aw_held_q <= 1'b0;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                wdata_q  <= s_wdata;
                wstrb_q  <= s_wstrb;
            end else if (b_hs) begin
                w_held_q <= 1'b0;
            end
            if (ar_hs) begin
                ar_held_q <= 1'b1;
                araddr_q  <= s_araddr;
            end else if (r_hs) begin
                ar_held_q <= 1'b0;
            end
        end
    end

    // Read data: zero on acceptance so DECERR/SLVERR return 0, loaded on completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (ar_hs) begin
            rdata_q <= '0;
        end else if (r_capture) begin
            rdata_q <= rdata;
        end
    end

    axil_reg_chan #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wr_chan (
        .clk       (clk),
        .rstn      (rstn),
        .start     (w_start),
        .in_win    (addr_in_window(awaddr_q, BASE_ADDR, WIN_BITS)),
        .done      (wready),
        .resp_ready(s_bready),
        .req       (wen),
        .resp_valid(s_bvalid),
        .resp      (s_bresp),
        .state     (w_chan_state)
    );

    axil_reg_chan #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rd_chan (
        .clk       (clk),
        .rstn      (rstn),
        .start     (r_start),
        .in_win    (addr_in_window(araddr_q, BASE_ADDR, WIN_BITS)),
        .done      (rvalid),
        .resp_ready(s_rready),
        .req       (ren),
        .resp_valid(s_rvalid),
        .resp      (s_rresp),
        .state     (r_chan_state)
    );

    assign s_awready = ~aw_held_q;
    assign s_wready  = ~w_held_q;
    assign s_arready = ~ar_held_q;
    assign waddr     = addr_offset(awaddr_q, WIN_BITS);
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign raddr     = addr_offset(araddr_q, WIN_BITS);
    assign s_rdata   = rdata_q;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Self-checking bench for axil_reg_bridge: directed test-plan steps plus randomized
// single-channel transactions checked against a window/offset/latency model.
module tb_axil_reg_bridge;

    localparam int TO_CYC = 16;

    logic        clk, rstn;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, waddr, wdata, raddr, rdata;
    logic [3:0]  s_wstrb, wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;
    logic        wen, wready, ren, rvalid;

    int n_chk = 0;
    int n_err = 0;

    axil_reg_bridge #(
        .BASE_ADDR  (32'h4000_0000),
        .WIN_BITS   (12),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_awaddr (s_awaddr),
        .s_awvalid(s_awvalid),
        .s_awready(s_awready),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_wvalid (s_wvalid),
        .s_wready (s_wready),
        .s_bresp  (s_bresp),
        .s_bvalid (s_bvalid),
        .s_bready (s_bready),
        .s_araddr (s_araddr),
        .s_arvalid(s_arvalid),
        .s_arready(s_arready),
        .s_rdata  (s_rdata),
        .s_rresp  (s_rresp),
        .s_rvalid (s_rvalid),
        .s_rready (s_rready),
        .waddr    (waddr),
        .wdata    (wdata),
        .wen      (wen),
        .wstrb    (wstrb),
        .wready   (wready),
        .raddr    (raddr),
        .ren      (ren),
        .rdata    (rdata),
        .rvalid   (rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: window is 0x4000_0000 .. 0x4000_0FFF, downstream sees the low 12 bits
    function automatic bit m_in_win(input logic [31:0] a);
        return (a >> 12) == (32'h4000_0000 >> 12);
    endfunction

    function automatic logic [31:0] m_off(input logic [31:0] a);
        return a % 32'h1000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_readys"}, {29'd0, s_awready, s_wready, s_arready}, 32'd7);
        chk({tag, "_zeros"}, {31'd0, |{s_bresp, s_bvalid, s_rdata, s_rresp, s_rvalid, waddr,
                                       wdata, wen, wstrb, raddr, ren}}, 32'd0);
    endtask

    // One write; wdelay<0 means downstream never completes (timeout builds only)
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_at, input int w_at,
                            input int wdelay, input int bhold);
        bit          inw, aw_sent, w_sent, aw_taking, w_taking, got_b, wlow_ok, bstable;
        int          h, b_c, wen_cnt, wr_at, exp_lat;
        logic [1:0]  exp_resp;
        logic [31:0] cw_addr, cw_data;
        logic [3:0]  cw_strb;
        inw = m_in_win(addr);
        exp_resp = !inw ? 2'b11 : (wdelay < 0 ? 2'b10 : 2'b00);
        exp_lat = 2 + (wdelay < 0 ? TO_CYC : wdelay);
        aw_sent = 0; w_sent = 0; aw_taking = 0; w_taking = 0; got_b = 0; wlow_ok = 1;
        h = 0; b_c = 0; wen_cnt = 0; wr_at = -1;
        cw_addr = 0; cw_data = 0; cw_strb = 0;
        for (int c = 0; c < 300 && !got_b; c++) begin
            if (aw_taking) begin s_awvalid = 0; aw_sent = 1; aw_taking = 0; end
            if (w_taking) begin s_wvalid = 0; w_sent = 1; w_taking = 0; end
            wready = 0;
            if (wen) begin
                wen_cnt++;
                cw_addr = waddr; cw_data = wdata; cw_strb = wstrb;
                if (wdelay >= 0) wr_at = c + wdelay;
            end
            if (wr_at >= 0 && c == wr_at) wready = 1;
            if (w_sent && !aw_sent && s_wready !== 1'b0) wlow_ok = 0;
            if (s_bvalid) begin
                got_b = 1;
                b_c = c;
            end else begin
                if (!aw_sent && !s_awvalid && c >= aw_at) begin s_awvalid = 1; s_awaddr = addr; end
                if (!w_sent && !s_wvalid && c >= w_at) begin
                    s_wvalid = 1; s_wdata = data; s_wstrb = strb;
                end
                if (s_awvalid && s_awready) aw_taking = 1;
                if (s_wvalid && s_wready) w_taking = 1;
                if ((aw_taking && (w_sent || w_taking)) || (w_taking && aw_sent)) h = c;
                tick();
            end
        end
        wready = 0;
        s_awvalid = 0; s_wvalid = 0;
        chk("b_seen", {31'd0, got_b}, 32'd1);
        // Stray completions while in RESP must not disturb the held response
        bstable = 1;
        for (int k = 0; k < bhold; k++) begin
            if (s_bvalid !== 1'b1 || s_bresp !== exp_resp) bstable = 0;
            if (wen) wen_cnt++;
            wready = (k == 0);
            tick();
        end
        wready = 0;
        if (s_bvalid !== 1'b1 || s_bresp !== exp_resp) bstable = 0;
        chk("b_stable", {31'd0, bstable}, 32'd1);
        chk("bresp", {30'd0, s_bresp}, {30'd0, exp_resp});
        chk("wen_pulses", wen_cnt, inw ? 32'd1 : 32'd0);
        if (w_at < aw_at) chk("wready_low_after_w", {31'd0, wlow_ok}, 32'd1);
        if (inw) begin
            chk("waddr", cw_addr, m_off(addr));
            chk("wdata", cw_data, data);
            chk("wstrb", {28'd0, cw_strb}, {28'd0, strb});
            chk("b_latency", b_c - (h + 1), exp_lat);
        end
        s_bready = 1;
        tick();
        s_bready = 0;
        chk("b_done", {29'd0, s_bvalid, s_awready, s_wready}, 32'd3);
    endtask

    // One read; rdelay<0 means downstream never completes (timeout builds only)
    task automatic do_read(input logic [31:0] addr, input logic [31:0] value,
                           input int rdelay, input int rhold);
        bit          inw, ar_taking, ar_sent, got_r, rstable;
        int          h, r_c, ren_cnt, rd_at, exp_lat;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data, cr_addr;
        inw = m_in_win(addr);
        exp_resp = !inw ? 2'b11 : (rdelay < 0 ? 2'b10 : 2'b00);
        exp_data = (inw && rdelay >= 0) ? value : 32'd0;
        exp_lat = 2 + (rdelay < 0 ? TO_CYC : rdelay);
        ar_taking = 0; ar_sent = 0; got_r = 0;
        h = 0; r_c = 0; ren_cnt = 0; rd_at = -1; cr_addr = 0;
        for (int c = 0; c < 300 && !got_r; c++) begin
            if (ar_taking) begin s_arvalid = 0; ar_sent = 1; ar_taking = 0; end
            rvalid = 0;
            rdata = $urandom;
            if (ren) begin
                ren_cnt++;
                cr_addr = raddr;
                if (rdelay >= 0) rd_at = c + rdelay;
            end
            if (rd_at >= 0 && c == rd_at) begin rvalid = 1; rdata = value; end
            if (s_rvalid) begin
                got_r = 1;
                r_c = c;
            end else begin
                if (!ar_sent && !s_arvalid) begin s_arvalid = 1; s_araddr = addr; end
                if (s_arvalid && s_arready) begin ar_taking = 1; h = c; end
                tick();
            end
        end
        rvalid = 0;
        s_arvalid = 0;
        chk("r_seen", {31'd0, got_r}, 32'd1);
        rstable = 1;
        for (int k = 0; k < rhold; k++) begin
            if (s_rvalid !== 1'b1 || s_rresp !== exp_resp || s_rdata !== exp_data) rstable = 0;
            if (ren) ren_cnt++;
            rvalid = (k == 0);
            rdata = ~value;
            tick();
        end
        rvalid = 0;
        if (s_rvalid !== 1'b1 || s_rresp !== exp_resp || s_rdata !== exp_data) rstable = 0;
        chk("r_stable", {31'd0, rstable}, 32'd1);
        chk("rresp", {30'd0, s_rresp}, {30'd0, exp_resp});
        chk("rdata", s_rdata, exp_data);
        chk("ren_pulses", ren_cnt, inw ? 32'd1 : 32'd0);
        if (inw) begin
            chk("raddr", cr_addr, m_off(addr));
            chk("r_latency", r_c - (h + 1), exp_lat);
        end
        s_rready = 1;
        tick();
        s_rready = 0;
        chk("r_done", {30'd0, s_rvalid, s_arready}, 32'd1);
    endtask

    initial begin
        bit          resp_seen;
        logic [31:0] a;
        rstn = 0;
        s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0; s_bready = 0;
        s_araddr = 0; s_arvalid = 0; s_rready = 0;
        wready = 0; rdata = 0; rvalid = 0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rstn = 1;
        tick();

        // Stray completions while both channels idle are ignored
        wready = 1; rvalid = 1; rdata = 32'hDEAD_BEEF;
        tick();
        wready = 0; rvalid = 0;
        tick();
        chk("idle_stray", {29'd0, s_bvalid, s_rvalid, |s_rdata}, 32'd0);

        // Same-cycle AW/W, immediate completion
        do_write(32'h4000_0004, 32'h0000_1234, 4'hF, 0, 0, 0, 2);
        // W three cycles ahead of AW
        do_write(32'h4000_0010, 32'hA5A5_0001, 4'h3, 3, 0, 1, 1);
        // AW ahead of W
        do_write(32'h4000_0FFC, 32'h0BAD_F00D, 4'h8, 0, 2, 2, 0);
        // Read with rvalid five cycles after ren, held for 4 cycles of rready=0
        do_read(32'h4000_0008, 32'hCAFE_F00D, 5, 4);
        // Out-of-window accesses on both sides of the window
        do_write(32'h5000_0000, 32'h1111_2222, 4'hF, 0, 0, 0, 1);
        do_read(32'h3FFF_FFFC, 32'h7777_7777, 0, 2);
        do_read(32'h4000_1000, 32'h7777_7777, 0, 0);

`ifdef AXIL_BRIDGE_TIMEOUT_EN
        do_write(32'h4000_0020, 32'h0000_00AA, 4'hF, 0, 0, -1, 3);
        do_read(32'h4000_0024, 32'h1234_5678, -1, 3);
`endif

        // Randomized single transactions against the model
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            if ($urandom_range(0, 9) < 7) a = 32'h4000_0000 | (a & 32'h0000_0FFC);
            else if (m_in_win(a)) a = a ^ 32'h8000_0000;
            do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 9) < 7) a = 32'h4000_0000 | (a & 32'h0000_0FFC);
            else if (m_in_win(a)) a = a ^ 32'h8000_0000;
            do_read(a, $urandom, $urandom_range(0, 6), $urandom_range(0, 3));
        end

        // Concurrent write and read left waiting, then reset mid-transaction
        s_awaddr = 32'h4000_0040; s_awvalid = 1;
        s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF; s_wvalid = 1;
        s_araddr = 32'h4000_0044; s_arvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        for (int k = 0; k < 4; k++) tick();
        #3 rstn = 0;
        #1;
        chk_reset_outputs("async_reset");
        tick();
        rstn = 1;
        resp_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (s_bvalid || s_rvalid) resp_seen = 1;
            tick();
        end
        chk("no_resp_after_abort", {31'd0, resp_seen}, 32'd0);
        do_write(32'h4000_0048, 32'h600D_600D, 4'hF, 0, 0, 1, 0);
        do_read(32'h4000_004C, 32'h0123_4567, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
